// File: rtl/write_order_scheduler.sv
// Per-slave W-channel sequencer: remembers AW grant order as {master, AWLEN}
// and steers W bursts from those masters in the same order, checking lengths.
module write_order_scheduler #(
  parameter int masters       = 2,
  parameter int LEN_WIDTH     = 4,
  parameter int pending_depth = 8,
  localparam int MW = (masters > 1) ? $clog2(masters) : 1,
  localparam int PW = $clog2(pending_depth)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 aw_push,
  input  logic [MW-1:0]        aw_master,
  input  logic [LEN_WIDTH-1:0] aw_len,
  input  logic                 w_beat,
  input  logic                 w_last,
  output logic                 order_full,
  output logic                 w_allow,
  output logic [MW-1:0]        w_src_master,
  output logic [LEN_WIDTH-1:0] beat_cnt,
  output logic [PW:0]          outstanding,
  output logic                 len_err,
  output logic                 len_err_sticky
);

  localparam logic [PW:0] DEPTH_C = (PW+1)'(pending_depth);

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (v == '1) ? v : v + LEN_WIDTH'(1);
  endfunction

  logic [MW-1:0]        mst_mem [pending_depth];
  logic [LEN_WIDTH-1:0] len_mem [pending_depth];

  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]          count_q, count_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 len_err_q, len_err_d;
  logic                 sticky_q, sticky_d;

  logic                 full, allow, push, pop;
  logic [MW-1:0]        head_mst;
  logic [LEN_WIDTH-1:0] head_len;

  always_comb begin
    full       = (count_q == DEPTH_C);
    allow      = (count_q != '0);
    head_mst   = mst_mem[rd_ptr_q];
    head_len   = len_mem[rd_ptr_q];
    // full is judged on the current count, so a same-cycle pop cannot make room
    push       = aw_push & ~full;
    pop        = w_beat & w_last & allow;

    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    beat_cnt_d = beat_cnt_q;
    if (pop)
      beat_cnt_d = '0;
    else if (w_beat & allow & ~w_last)
      beat_cnt_d = sat_inc(beat_cnt_q);

    len_err_d  = (aw_push & full)
               | (w_beat & ~allow)
               | (w_beat & allow & (w_last ? (beat_cnt_q != head_len)
                                           : (beat_cnt_q == head_len)));
    sticky_d   = sticky_q | len_err_d;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
      sticky_q   <= sticky_d;
    end
  end

  // Order storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge ACLK) begin
    if (ARESETn && push) begin
      mst_mem[wr_ptr_q] <= aw_master;
      len_mem[wr_ptr_q] <= aw_len;
    end
  end

  assign order_full     = full;
  assign w_allow        = allow;
  assign w_src_master   = allow ? head_mst : '0;
  assign beat_cnt       = beat_cnt_q;
  assign outstanding    = count_q;
  assign len_err        = len_err_q;
  assign len_err_sticky = sticky_q;

endmodule
